// File: rtl/banked_data_mem.sv
// banked_data_mem: single-port word memory with per-byte write enables,
// a one-cycle registered read path and a self-clearing init sweep that
// runs after every reset.
//
// Handshake: a request is accepted on a rising edge where ReqValid and
// ReqReady are both 1. ReqReady depends only on internal state, never on
// ReqValid. A requester may hold or change its request freely while
// ReqReady is 0. Every accepted read produces exactly one RdValid pulse
// on the following cycle. Accepted writes never produce RdValid.
module banked_data_mem #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  MemWrite,
  input  logic [ADDR_W-1:0]     Address,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [DATA_W/8-1:0]   ByteEn,
  output logic                  RdValid,
  output logic [DATA_W-1:0]     ReadData,
  output logic                  Busy,
  output logic                  DbgState
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam int unsigned       NBYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                rd_accept;
  logic                wr_accept;

  // Requests are only taken in IDLE; reset priority is handled in the
  // register block, which ignores every _d value while Rst is high.
  assign accept    = ReqValid && (state_q == ST_IDLE);
  assign rd_accept = accept && !MemWrite;
  assign wr_accept = accept && MemWrite;

  assign ReqReady  = (state_q == ST_IDLE);
  assign Busy      = (state_q == ST_INIT);
  assign RdValid   = rd_valid_q;
  assign ReadData  = rd_data_q;
  assign DbgState  = state_q;

  // Next-state logic: sweep walks 0..DEPTH-1 once, then IDLE forever.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_INIT: begin
        if (sweep_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (rd_accept) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[Address];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control registers with synchronous reset back into the sweep.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage writes: sweep clears one word per cycle, IDLE applies byte-masked writes.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state_q == ST_INIT) begin
        mem_q[sweep_q] <= INIT_VAL;
      end else if (wr_accept) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (ByteEn[b]) begin
            mem_q[Address][8*b +: 8] <= WriteData[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_data_mem.sv
// tb_banked_data_mem: directed table-driven bench for banked_data_mem
// configured with DATA_W=32, ADDR_W=4, INIT_VAL=0.
module tb_banked_data_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NB     = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [NB-1:0]     byte_en;
  logic              rd_valid;
  logic [DATA_W-1:0] read_data;
  logic              busy;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q [$];

  banked_data_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_VAL ('0)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .ReqValid  (req_valid),
    .ReqReady  (req_ready),
    .MemWrite  (mem_write),
    .Address   (address),
    .WriteData (write_data),
    .ByteEn    (byte_en),
    .RdValid   (rd_valid),
    .ReadData  (read_data),
    .Busy      (busy),
    .DbgState  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
    logic              exp_rv;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input logic w, input int a,
                              input logic [DATA_W-1:0] d, input logic [NB-1:0] be,
                              input logic rv, input logic [DATA_W-1:0] ed);
    vec_t t;
    t.valid    = v;
    t.write    = w;
    t.addr     = ADDR_W'(a);
    t.wdata    = d;
    t.be       = be;
    t.exp_rv   = rv;
    t.exp_data = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    req_valid  = v;
    mem_write  = w;
    address    = a;
    write_data = d;
    byte_en    = be;
  endtask

  // Counts the cycles Busy stays high after reset release; expects DEPTH.
  // Keeps a write to addr 5 presented the whole time, which must be ignored.
  task automatic sweep_and_count(input string name);
    int n;
    logic saw_bad;
    n = 0;
    saw_bad = 1'b0;
    drive(1'b1, 1'b1, 4'd5, 32'hAAAA_AAAA, 4'hF);
    while (busy && n < 40) begin
      if (req_ready || rd_valid) saw_bad = 1'b1;
      n++;
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    check({name, "_busy_cycles"}, DATA_W'(n), DATA_W'(16));
    check({name, "_init_ready_or_rdvalid"}, DATA_W'(saw_bad), '0);
    check({name, "_ready_after"}, DATA_W'(req_ready), 32'd1);
    check({name, "_state_idle"}, DATA_W'(dbg_state), 32'd1);
  endtask

  task automatic single_read(input string name, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] exp);
    drive(1'b1, 1'b0, a, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    check({name, "_rdvalid"}, DATA_W'(rd_valid), 32'd1);
    check({name, "_data"}, read_data, exp);
  endtask

  initial begin
    vec_t v;
    logic [DATA_W-1:0] e;
    drive(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    check("reset_busy", DATA_W'(busy), 32'd1);
    check("reset_ready", DATA_W'(req_ready), 32'd0);
    check("reset_rdvalid", DATA_W'(rd_valid), 32'd0);
    check("reset_rdata", read_data, 32'h0);
    rst = 1'b0;
    sweep_and_count("sweep1");

    //               v  w   a   wdata          be    rv  data
    vecs[0]  = mk(1, 0, 15, 32'h0,          4'h0, 1, 32'h0000_0000);
    vecs[1]  = mk(1, 0,  5, 32'h0,          4'h0, 1, 32'h0000_0000);
    vecs[2]  = mk(1, 1,  3, 32'hDEAD_BEEF,  4'hF, 0, 32'h0000_0000);
    vecs[3]  = mk(1, 0,  3, 32'h0,          4'h0, 1, 32'hDEAD_BEEF);
    vecs[4]  = mk(1, 1,  3, 32'h1122_3344,  4'h5, 0, 32'hDEAD_BEEF);
    vecs[5]  = mk(1, 0,  3, 32'h0,          4'h0, 1, 32'hDE22_BE44);
    vecs[6]  = mk(0, 0,  3, 32'h0,          4'h0, 0, 32'hDE22_BE44);
    vecs[7]  = mk(0, 1,  9, 32'h5555_5555,  4'hF, 0, 32'hDE22_BE44);
    vecs[8]  = mk(0, 0,  0, 32'h0,          4'h0, 0, 32'hDE22_BE44);
    vecs[9]  = mk(1, 1,  3, 32'hFFFF_FFFF,  4'h0, 0, 32'hDE22_BE44);
    vecs[10] = mk(1, 0,  3, 32'h0,          4'h0, 1, 32'hDE22_BE44);
    vecs[11] = mk(1, 1,  7, 32'h0BAD_F00D,  4'hF, 0, 32'hDE22_BE44);
    vecs[12] = mk(1, 0,  7, 32'h0,          4'h0, 1, 32'h0BAD_F00D);
    vecs[13] = mk(1, 1, 15, 32'h1234_5678,  4'h8, 0, 32'h0BAD_F00D);
    vecs[14] = mk(1, 0, 15, 32'h0,          4'h0, 1, 32'h1200_0000);
    vecs[15] = mk(1, 1, 15, 32'h9999_99AB,  4'h1, 0, 32'h1200_0000);
    vecs[16] = mk(1, 0, 15, 32'h0,          4'h0, 1, 32'h1200_00AB);
    vecs[17] = mk(1, 0,  9, 32'h0,          4'h0, 1, 32'h0000_0000);
    vecs[18] = mk(1, 0,  7, 32'h0,          4'h0, 1, 32'h0BAD_F00D);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.valid, v.write, v.addr, v.wdata, v.be);
      if (v.valid && !v.write) exp_q.push_back(v.exp_data);
      tick();
      check($sformatf("vec%0d_rdvalid", i), DATA_W'(rd_valid), DATA_W'(v.exp_rv));
      if (rd_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d_sb_data", i), read_data, e);
      end
      check($sformatf("vec%0d_rdata", i), read_data, v.exp_data);
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    check("sb_queue_empty", DATA_W'(exp_q.size()), '0);

    // Pending read result aborted by reset, with a read presented during reset.
    drive(1'b1, 1'b0, 4'd3, '0, '0);
    tick();
    check("pre_abort_rdvalid", DATA_W'(rd_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_read_rdvalid", DATA_W'(rd_valid), 32'd0);
    check("rst_read_rdata", read_data, 32'h0);
    check("rst_read_busy", DATA_W'(busy), 32'd1);
    check("rst_read_ready", DATA_W'(req_ready), 32'd0);
    rst = 1'b0;
    sweep_and_count("sweep2");
    single_read("post_rst_a3", 4'd3, 32'h0);
    single_read("post_rst_a7", 4'd7, 32'h0);

    // Reset mid-sweep must restart the full sweep from address 0.
    drive(1'b1, 1'b1, 4'd15, 32'hCAFE_F00D, 4'hF);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_and_count("sweep3");
    single_read("post_mid_a15", 4'd15, 32'h0);
    tick();
    check("idle_rdvalid_low", DATA_W'(rd_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
